video_rgb_downsampler: RTL and testbench



---
 rtl/video_rgb_downsampler_if.sv | 57 +++++
 rtl/video_rgb_downsampler.sv | 158 +++++++++++++++
 tb/tb_video_rgb_downsampler.sv | 209 ++++++++++++++++++++
 3 files changed

// File: rtl/video_rgb_downsampler_if.sv
// video_rgb_downsampler_if: 30-bit RGB sink, RGB565 source and status port.
// The slave modport is the downsampler side; the master modport is the environment side.
interface video_rgb_downsampler_if #(
  parameter int IDW = 29,
  parameter int ODW = 15,
  parameter int IEW = 1,
  parameter int OEW = 0
);
  logic [IDW:0] stream_in_data;
  logic         stream_in_startofpacket;
  logic         stream_in_endofpacket;
  logic [IEW:0] stream_in_empty;
  logic         stream_in_valid;
  logic         stream_in_ready;
  logic         slave_read;
  logic [31:0]  slave_readdata;
  logic         stream_out_ready;
  logic [ODW:0] stream_out_data;
  logic         stream_out_startofpacket;
  logic         stream_out_endofpacket;
  logic [OEW:0] stream_out_empty;
  logic         stream_out_valid;

  modport slave (
    input  stream_in_data,
    input  stream_in_startofpacket,
    input  stream_in_endofpacket,
    input  stream_in_empty,
    input  stream_in_valid,
    output stream_in_ready,
    input  slave_read,
    output slave_readdata,
    input  stream_out_ready,
    output stream_out_data,
    output stream_out_startofpacket,
    output stream_out_endofpacket,
    output stream_out_empty,
    output stream_out_valid
  );

  modport master (
    output stream_in_data,
    output stream_in_startofpacket,
    output stream_in_endofpacket,
    output stream_in_empty,
    output stream_in_valid,
    input  stream_in_ready,
    output slave_read,
    input  slave_readdata,
    output stream_out_ready,
    input  stream_out_data,
    input  stream_out_startofpacket,
    input  stream_out_endofpacket,
    input  stream_out_empty,
    input  stream_out_valid
  );
endinterface

// File: rtl/video_rgb_downsampler.sv
// video_rgb_downsampler: 30-bit RGB to RGB565, two-stage (offset add, saturate+pack).
// Define VIDEO_RGB_DOWNSAMPLER_DITHER_EN for 4x4 ordered dithering instead of rounding.
module video_rgb_downsampler #(
  parameter int          IDW        = 29,
  parameter int          ODW        = 15,
  parameter int          IEW        = 1,
  parameter int          OEW        = 0,
  parameter int          WIDTH      = 640,
  parameter logic [15:0] STATUS_IN  = 16'h0019,
  parameter logic [15:0] STATUS_OUT = 16'h0014
) (
  input logic clk,
  input logic reset,
  video_rgb_downsampler_if.slave bus
);

  logic       advance;
  logic       accept;
  logic [4:0] r_off;
  logic [4:0] g_off;

  assign advance = bus.stream_out_ready | ~bus.stream_out_valid;
  assign accept  = bus.stream_in_valid & advance;

`ifdef VIDEO_RGB_DOWNSAMPLER_DITHER_EN
  localparam int XW = (WIDTH > 1) ? $clog2(WIDTH) : 1;
  // Bayer matrix packed with entry {y,x} at nibble index 4*y+x
  localparam logic [63:0] BAYER = {
    4'd5, 4'd13, 4'd7, 4'd15,
    4'd9, 4'd1, 4'd11, 4'd3,
    4'd6, 4'd14, 4'd4, 4'd12,
    4'd10, 4'd2, 4'd8, 4'd0
  };

  logic [XW-1:0] x_q, x_d, pos_x;
  logic [1:0]    y_q, y_d, pos_y;
  logic [3:0]    bayer;

  // Pixel position: sop resyncs to origin, eop clears, wrap at line end
  always_comb begin
    pos_x = bus.stream_in_startofpacket ? '0 : x_q;
    pos_y = bus.stream_in_startofpacket ? '0 : y_q;
    x_d   = x_q;
    y_d   = y_q;
    if (accept) begin
      if (bus.stream_in_endofpacket) begin
        x_d = '0;
        y_d = '0;
      end else if (pos_x == XW'(WIDTH - 1)) begin
        x_d = '0;
        y_d = pos_y + 2'd1;
      end else begin
        x_d = pos_x + XW'(1);
        y_d = pos_y;
      end
    end
    bayer = BAYER[{pos_y, pos_x[1:0]} * 4 +: 4];
    r_off = {bayer, 1'b0};
    g_off = {1'b0, bayer};
  end

  // Position counter state
  always_ff @(posedge clk) begin
    if (reset) begin
      x_q <= '0;
      y_q <= '0;
    end else begin
      x_q <= x_d;
      y_q <= y_d;
    end
  end
`else
  assign r_off = 5'd16;
  assign g_off = 5'd8;
`endif

  logic        s1_valid_q, s1_valid_d;
  logic        s1_sop_q, s1_sop_d;
  logic        s1_eop_q, s1_eop_d;
  logic [10:0] s1_r_q, s1_r_d;
  logic [10:0] s1_g_q, s1_g_d;
  logic [10:0] s1_b_q, s1_b_d;
  logic        out_valid_q, out_valid_d;
  logic        out_sop_q, out_sop_d;
  logic        out_eop_q, out_eop_d;
  logic [15:0] out_data_q, out_data_d;
  logic [31:0] rdata_q, rdata_d;
  logic [4:0]  r5, b5;
  logic [5:0]  g6;

  // Stage 1 adds offsets, stage 2 saturates and packs; both hold on stall
  always_comb begin
    s1_valid_d  = s1_valid_q;
    s1_sop_d    = s1_sop_q;
    s1_eop_d    = s1_eop_q;
    s1_r_d      = s1_r_q;
    s1_g_d      = s1_g_q;
    s1_b_d      = s1_b_q;
    out_valid_d = out_valid_q;
    out_sop_d   = out_sop_q;
    out_eop_d   = out_eop_q;
    out_data_d  = out_data_q;
    r5 = s1_r_q[10] ? 5'h1f : s1_r_q[9:5];
    g6 = s1_g_q[10] ? 6'h3f : s1_g_q[9:4];
    b5 = s1_b_q[10] ? 5'h1f : s1_b_q[9:5];
    if (advance) begin
      s1_valid_d  = bus.stream_in_valid;
      s1_sop_d    = bus.stream_in_startofpacket;
      s1_eop_d    = bus.stream_in_endofpacket;
      s1_r_d      = {1'b0, bus.stream_in_data[29:20]} + {6'd0, r_off};
      s1_g_d      = {1'b0, bus.stream_in_data[19:10]} + {6'd0, g_off};
      s1_b_d      = {1'b0, bus.stream_in_data[9:0]} + {6'd0, r_off};
      out_valid_d = s1_valid_q;
      out_sop_d   = s1_sop_q;
      out_eop_d   = s1_eop_q;
      out_data_d  = {r5, g6, b5};
    end
    rdata_d = bus.slave_read ? {STATUS_OUT, STATUS_IN} : rdata_q;
  end

  // Pipeline and status registers
  always_ff @(posedge clk) begin
    if (reset) begin
      s1_valid_q  <= 1'b0;
      s1_sop_q    <= 1'b0;
      s1_eop_q    <= 1'b0;
      s1_r_q      <= '0;
      s1_g_q      <= '0;
      s1_b_q      <= '0;
      out_valid_q <= 1'b0;
      out_sop_q   <= 1'b0;
      out_eop_q   <= 1'b0;
      out_data_q  <= '0;
      rdata_q     <= '0;
    end else begin
      s1_valid_q  <= s1_valid_d;
      s1_sop_q    <= s1_sop_d;
      s1_eop_q    <= s1_eop_d;
      s1_r_q      <= s1_r_d;
      s1_g_q      <= s1_g_d;
      s1_b_q      <= s1_b_d;
      out_valid_q <= out_valid_d;
      out_sop_q   <= out_sop_d;
      out_eop_q   <= out_eop_d;
      out_data_q  <= out_data_d;
      rdata_q     <= rdata_d;
    end
  end

  assign bus.stream_in_ready          = advance;
  assign bus.stream_out_valid         = out_valid_q;
  assign bus.stream_out_startofpacket = out_sop_q;
  assign bus.stream_out_endofpacket   = out_eop_q;
  assign bus.stream_out_data          = out_data_q;
  assign bus.stream_out_empty         = '0;
  assign bus.slave_readdata           = rdata_q;

endmodule

// File: tb/tb_video_rgb_downsampler.sv
// tb_video_rgb_downsampler: directed vectors with hand-computed RGB565 results.
// Expected pixels follow VIDEO_RGB_DOWNSAMPLER_DITHER_EN when it is defined.
module tb_video_rgb_downsampler;

`ifdef VIDEO_RGB_DOWNSAMPLER_DITHER_EN
  localparam bit DITH = 1'b1;
`else
  localparam bit DITH = 1'b0;
`endif

  logic clk = 1'b0;
  logic reset;
  always #5 clk = ~clk;

  video_rgb_downsampler_if #(.IDW(29), .ODW(15), .IEW(1), .OEW(0)) bus ();

  video_rgb_downsampler #(.WIDTH(4)) dut (
    .clk  (clk),
    .reset(reset),
    .bus  (bus)
  );

  int n_run  = 0;
  int n_fail = 0;
  logic [17:0] expq[$];

  task automatic chk(input string tag, input logic [31:0] got,
                     input logic [31:0] exp);
    n_run++;
    if (got !== exp) begin
      n_fail++;
      $display("FAIL %s: got %h expected %h", tag, got, exp);
    end
  endtask

  // Dither-dependent expectation for R=10'h010: 0800 when set bit, else 0000
  function automatic logic [15:0] dv(input bit one);
    return (!DITH || one) ? 16'h0800 : 16'h0000;
  endfunction

  function automatic logic [15:0] k565(input int k);
    return {k[4:0], k[5:0], k[4:0]};
  endfunction

  task automatic send(input logic [29:0] d, input logic sop, input logic eop,
                      input logic [15:0] exp);
    int  n;
    bit  acc;
    n = 0;
    bus.stream_in_data          = d;
    bus.stream_in_startofpacket = sop;
    bus.stream_in_endofpacket   = eop;
    bus.stream_in_valid         = 1'b1;
    expq.push_back({sop, eop, exp});
    forever begin
      @(negedge clk);
      acc = bus.stream_in_ready;
      @(posedge clk);
      #1;
      if (acc) break;
      n++;
      if (n > 50) begin
        chk("accept_timeout", 1, 0);
        break;
      end
    end
    bus.stream_in_valid         = 1'b0;
    bus.stream_in_startofpacket = 1'b0;
    bus.stream_in_endofpacket   = 1'b0;
  endtask

  task automatic drain();
    int n;
    n = 0;
    while (expq.size() != 0 && n < 30) begin
      @(posedge clk);
      #1;
      n++;
    end
    chk("drain", expq.size(), 0);
  endtask

  // Scoreboard: every transferred beat must match the next expected beat
  always @(negedge clk) begin
    logic [17:0] e;
    if (!reset && bus.stream_out_valid && bus.stream_out_ready) begin
      if (expq.size() == 0) begin
        chk("extra_beat", {16'd0, bus.stream_out_data}, 32'hffff_ffff);
      end else begin
        e = expq.pop_front();
        chk("data", {16'd0, bus.stream_out_data}, {16'd0, e[15:0]});
        chk("sop", {31'd0, bus.stream_out_startofpacket}, {31'd0, e[17]});
        chk("eop", {31'd0, bus.stream_out_endofpacket}, {31'd0, e[16]});
      end
    end
  end

  initial begin
    reset                       = 1'b1;
    bus.stream_in_data          = '0;
    bus.stream_in_startofpacket = 1'b0;
    bus.stream_in_endofpacket   = 1'b0;
    bus.stream_in_empty         = '0;
    bus.stream_in_valid         = 1'b0;
    bus.slave_read              = 1'b0;
    bus.stream_out_ready        = 1'b1;
    repeat (3) @(posedge clk);
    #1;
    chk("rst_valid", {31'd0, bus.stream_out_valid}, 0);
    chk("rst_rdata", bus.slave_readdata, 0);
    chk("rst_data", {16'd0, bus.stream_out_data}, 0);
    chk("rst_empty", {31'd0, bus.stream_out_empty}, 0);
    chk("rst_ready", {31'd0, bus.stream_in_ready}, 1);
    reset = 1'b0;

    // Mid-grey, two-cycle latency
    send({10'h200, 10'h200, 10'h200}, 1'b1, 1'b0, 16'h8410);
    chk("lat1_valid", {31'd0, bus.stream_out_valid}, 0);
    @(posedge clk);
    #1;
    chk("lat2_valid", {31'd0, bus.stream_out_valid}, 1);
    chk("lat2_data", {16'd0, bus.stream_out_data}, 32'h8410);
    chk("lat2_sop", {31'd0, bus.stream_out_startofpacket}, 1);

    // Saturation and small values
    send({10'h3ff, 10'h3ff, 10'h3ff}, 1'b0, 1'b0, 16'hffff);
    send({10'h00f, 10'h00f, 10'h00f}, 1'b0, 1'b1, 16'h0020);
    drain();

    // Two 4-pixel lines of R=10'h010
    send({10'h010, 10'h000, 10'h000}, 1'b1, 1'b0, dv(0));
    send({10'h010, 10'h000, 10'h000}, 1'b0, 1'b0, dv(1));
    send({10'h010, 10'h000, 10'h000}, 1'b0, 1'b0, dv(0));
    send({10'h010, 10'h000, 10'h000}, 1'b0, 1'b0, dv(1));
    send({10'h010, 10'h000, 10'h000}, 1'b0, 1'b0, dv(1));
    send({10'h010, 10'h000, 10'h000}, 1'b0, 1'b0, dv(0));
    send({10'h010, 10'h000, 10'h000}, 1'b0, 1'b0, dv(1));
    send({10'h010, 10'h000, 10'h000}, 1'b0, 1'b1, dv(0));
    drain();

    // Backpressure with a dither-invariant burst
    bus.stream_out_ready = 1'b0;
    fork
      begin
        for (int k = 1; k <= 6; k++) begin
          send({10'(k * 32), 10'(k * 16), 10'(k * 32)}, k == 1, k == 6,
               k565(k));
        end
      end
      begin
        repeat (5) @(posedge clk);
        #2;
        chk("bp_ready", {31'd0, bus.stream_in_ready}, 0);
        chk("bp_valid", {31'd0, bus.stream_out_valid}, 1);
        for (int i = 0; i < 3; i++) begin
          chk("bp_hold", {16'd0, bus.stream_out_data}, {16'd0, k565(1)});
          @(posedge clk);
          #2;
        end
        chk("bp_ready2", {31'd0, bus.stream_in_ready}, 0);
        bus.stream_out_ready = 1'b1;
      end
    join
    drain();

    // Resync on mid-line sop, then eop clears position
    send({10'h010, 10'h000, 10'h000}, 1'b1, 1'b0, dv(0));
    send({10'h010, 10'h000, 10'h000}, 1'b0, 1'b0, dv(1));
    send({10'h010, 10'h000, 10'h000}, 1'b1, 1'b0, dv(0));
    send({10'h010, 10'h000, 10'h000}, 1'b0, 1'b1, dv(1));
    send({10'h010, 10'h000, 10'h000}, 1'b0, 1'b0, dv(0));
    send({10'h010, 10'h000, 10'h000}, 1'b0, 1'b1, dv(1));
    drain();

    // Status read
    bus.slave_read = 1'b1;
    @(posedge clk);
    #1;
    bus.slave_read = 1'b0;
    chk("rd", bus.slave_readdata, 32'h0014_0019);
    @(posedge clk);
    #1;
    chk("rd_hold", bus.slave_readdata, 32'h0014_0019);

    // Reset with a beat in flight
    bus.stream_in_data          = {10'h3ff, 10'h000, 10'h3ff};
    bus.stream_in_startofpacket = 1'b1;
    bus.stream_in_valid         = 1'b1;
    @(posedge clk);
    #1;
    bus.stream_in_valid         = 1'b0;
    bus.stream_in_startofpacket = 1'b0;
    reset = 1'b1;
    @(posedge clk);
    #1;
    chk("mid_rst_valid", {31'd0, bus.stream_out_valid}, 0);
    chk("mid_rst_rdata", bus.slave_readdata, 0);
    reset = 1'b0;
    repeat (3) @(posedge clk);
    #1;
    chk("post_rst_valid", {31'd0, bus.stream_out_valid}, 0);
    send({10'h200, 10'h200, 10'h200}, 1'b1, 1'b1, 16'h8410);
    drain();

    $display("[TB] %0d tests run, %0d failed", n_run, n_fail);
    $finish;
  end

endmodule
